// File: rtl/ppc_disp_pkg.sv
// ppc_disp_pkg: shared constants for the ping-pong counter display scanner.
// It holds the active-low 7-segment codes, the digit slot indices and the
// all-anodes-off value used by ppc_seg_decode and ppc_display_scan.
package ppc_disp_pkg;

  // Active-low segment codes, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Direction glyphs: a bar at the top (a) for up, at the bottom (d) for down
  localparam logic [6:0] SEG_UP    = 7'b1111110;
  localparam logic [6:0] SEG_DOWN  = 7'b1110111;

  // Digit slots, index 0 is the rightmost digit
  localparam logic [1:0] DIG_ONES   = 2'd0;
  localparam logic [1:0] DIG_TENS   = 2'd1;
  localparam logic [1:0] DIG_BOUNCE = 2'd2;
  localparam logic [1:0] DIG_DIR    = 2'd3;

  // All anodes driven high: every digit dark
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-hot anode pattern for a digit slot
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ppc_seg_decode.sv
// ppc_seg_decode: combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not decimal digits and are shown blank.
module ppc_seg_decode
  import ppc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; anything outside 0..9 falls through to blank
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ppc_display_scan.sv
// ppc_display_scan: drives a 4-digit active-low multiplexed 7-segment display
// from the ping-pong counter's value and direction, and counts direction
// turnarounds (bounces).
//   digit 0: ones of the counter value   digit 1: tens of the counter value
//   digit 2: bounce count mod 10         digit 3: direction glyph
// Optional build macro PPC_LEADING_ZERO_BLANK_EN: when defined, the tens digit
// is blanked instead of showing 0.
module ppc_display_scan
  import ppc_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BOUNCE_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          cnt_in,
  input  logic                dir_in,
  input  logic                freeze,
  output logic [3:0]          an,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  // Divider width; a single-cycle dwell still needs one bit of storage
  localparam int DIV_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_CYCLES - 1);

  // Saturating increment for the bounce counter: sticks at all-ones
  function automatic logic [BOUNCE_W-1:0] sat_inc(input logic [BOUNCE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [3:0]       cnt_q;
  logic             dir_q;
  logic             primed;
  logic [DIV_W-1:0] div;
  logic [1:0]       idx;

  logic             bounce_hit;
  logic             tens_nz;
  logic [3:0]       ones_bcd;
  logic [3:0]       bounce_bcd;
  logic [3:0]       dig_bcd;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_next;

  // ---- stage 1: sample the counter (held while frozen) ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      dir_q  <= 1'b1;
      primed <= 1'b0;
    end else if (!freeze) begin
      cnt_q  <= cnt_in;
      dir_q  <= dir_in;
      primed <= 1'b1;
    end
  end

  // A turnaround is judged against the last unfrozen direction, so a change
  // made during freeze is counted once on release if it still differs.
  assign bounce_hit = !freeze && primed && (dir_in != dir_q);

  // Bounce counter, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bounce_cnt <= '0;
    end else if (bounce_hit) begin
      bounce_cnt <= sat_inc(bounce_cnt);
    end
  end

  // Scan divider: each digit dwells DIGIT_CYCLES cycles, freeze has no effect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
      idx <= DIG_ONES;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= idx + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Split the sampled value into decimal digits; max value is 15
  assign tens_nz    = (cnt_q >= 4'd10);
  assign ones_bcd   = tens_nz ? (cnt_q - 4'd10) : cnt_q;
  assign bounce_bcd = 4'(bounce_cnt % 10);

  // Pick the BCD value for the digit currently selected
  always_comb begin
    dig_bcd = 4'd0;
    case (idx)
      DIG_ONES:   dig_bcd = ones_bcd;
      DIG_TENS:   dig_bcd = {3'b000, tens_nz};
      DIG_BOUNCE: dig_bcd = bounce_bcd;
      default:    dig_bcd = 4'd0;
    endcase
  end

  ppc_seg_decode u_dec (
    .bcd (dig_bcd),
    .seg (dec_seg)
  );

  // Final segment pattern: direction glyph on digit 3, optional zero blanking
  always_comb begin
    seg_next = dec_seg;
    if (idx == DIG_DIR) begin
      seg_next = dir_q ? SEG_UP : SEG_DOWN;
    end
`ifdef PPC_LEADING_ZERO_BLANK_EN
    if ((idx == DIG_TENS) && !tens_nz) begin
      seg_next = SEG_BLANK;
    end
`endif
  end

  // ---- stage 2: output registers; an and seg always move together ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= anode_sel(idx);
      seg <= seg_next;
      dp  <= ~(freeze && (idx == DIG_ONES));
    end
  end

endmodule

// File: tb/tb_ppc_display_scan.sv
// tb_ppc_display_scan: scoreboard bench for ppc_display_scan (DIGIT_CYCLES=2).
// A behavioural model predicts each cycle's outputs from elapsed time and the
// last unfrozen sample; a negedge monitor pops and compares.
module tb_ppc_display_scan;

  localparam int DC = 2;
  localparam int BW = 8;
  localparam int BMAX = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    cnt_in;
  logic          dir_in;
  logic          freeze;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic [BW-1:0] bounce_cnt;

  always #5 clk = ~clk;

  ppc_display_scan #(.DIGIT_CYCLES(DC), .BOUNCE_W(BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_in     (cnt_in),
    .dir_in     (dir_in),
    .freeze     (freeze),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .bounce_cnt (bounce_cnt)
  );

  typedef struct packed {
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic [BW-1:0] bc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  // Model state: cycles since reset, last unfrozen sample, bounce total
  int   m_t;
  int   m_cnt;
  bit   m_dir;
  bit   m_have;
  int   m_bounce;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input int dg);
    case (dg)
      0: return glyph(m_cnt % 10);
      1: begin
`ifdef PPC_LEADING_ZERO_BLANK_EN
        if (m_cnt / 10 == 0) return 7'b1111111;
`endif
        return glyph(m_cnt / 10);
      end
      2: return glyph(m_bounce % 10);
      default: return m_dir ? 7'b1111110 : 7'b1110111;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    exp_t e;
    int   dg;
    if (!rst_n) begin
      m_t = 0; m_cnt = 0; m_dir = 1'b1; m_have = 1'b0; m_bounce = 0;
      e.an = 4'b1111; e.seg = 7'h7F; e.dp = 1'b1; e.bc = '0;
    end else begin
      dg    = (m_t / DC) % 4;
      e.an  = 4'b1111;
      e.an[dg] = 1'b0;
      e.seg = digit_seg(dg);
      e.dp  = !(freeze && dg == 0);
      if (!freeze) begin
        if (m_have && dir_in != m_dir) m_bounce = (m_bounce < BMAX) ? m_bounce + 1 : BMAX;
        m_cnt  = int'(cnt_in);
        m_dir  = dir_in;
        m_have = 1'b1;
      end
      e.bc = BW'(m_bounce);
      m_t++;
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Monitor: compare the registered outputs mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("an",         32'(an),         32'(mon_e.an));
      chk("seg",        32'(seg),        32'(mon_e.seg));
      chk("dp",         32'(dp),         32'(mon_e.dp));
      chk("bounce_cnt", 32'(bounce_cnt), 32'(mon_e.bc));
    end
  end

  initial begin
    rst_n = 1'b0; cnt_in = 4'd0; dir_in = 1'b1; freeze = 1'b0;
    run(2);
    rst_n = 1'b1;

    // Steady value, up direction
    cnt_in = 4'd13; dir_in = 1'b1;
    run(16);

    // Single-digit value exercises the tens digit
    cnt_in = 4'd5;
    run(12);

    // Two turnarounds, ten cycles apart
    dir_in = 1'b0; run(10);
    dir_in = 1'b1; run(10);

    // Freeze holds display and defers bounce detection
    cnt_in = 4'd7; run(4);
    freeze = 1'b1; run(2);
    cnt_in = 4'd2; dir_in = 1'b0; run(10);
    freeze = 1'b0; run(10);

    // Randomised traffic with occasional freeze and reset
    for (int i = 0; i < 400; i++) begin
      cnt_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) dir_in = ~dir_in;
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1; freeze = 1'b0;

    // Saturation: a turnaround every cycle
    for (int i = 0; i < 260; i++) begin
      dir_in = ~dir_in;
      step();
    end
    chk("sat_bc", 32'(bounce_cnt), 32'(BMAX));
    run(8);

    // Reset in the middle of a scan
    run(3);
    rst_n = 1'b0;
    step();
    chk("rst_bc", 32'(bounce_cnt), 32'd0);
    chk("rst_an", 32'(an), 32'hF);
    rst_n = 1'b1;
    run(10);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
